// File: rtl/btn_io_pkg.sv
// Shared constants and types for the button input port and its debouncer.
package btn_io_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

  typedef logic [DATA_W-1:0] bus_word_t;
  typedef logic [ADDR_W-1:0] bus_addr_t;

  localparam bus_addr_t ADDR_STAT_DEF = 12'd111;
  localparam bus_addr_t ADDR_EVT_DEF  = 12'd112;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchroniser, stability counter and debounced level.
// rise is combinational and marks the cycle whose falling edge will set level.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic res,
  input  logic btn_n,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = ~btn_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any sample matching the current level restarts the stability window.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge res) begin
    if (!res) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = level_d & ~level_q;

endmodule

// File: rtl/btn_input_port.sv
// Memory-mapped push-button input port: debounced status and sticky press events.
// Define BTN_INPUT_IRQ_EN to add the irq output (registered OR of the event bits).
module btn_input_port
  import btn_io_pkg::*;
#(
  parameter int        NBTN       = 2,
  parameter int        DEB_CYCLES = 500000,
  parameter int        CNT_W      = 20,
  parameter bus_addr_t ADDR_STAT  = ADDR_STAT_DEF,
  parameter bus_addr_t ADDR_EVT   = ADDR_EVT_DEF
) (
  input  logic            clk,
  input  logic            res,
  input  logic [NBTN-1:0] btn,
  input  bus_addr_t       addr,
  input  logic            sel,
  input  logic            ld,
  input  bus_word_t       wdata,
  output bus_word_t       rdata,
  output logic            hit,
  output logic [NBTN-1:0] pressed
`ifdef BTN_INPUT_IRQ_EN
  ,
  output logic            irq
`endif
);

  logic [NBTN-1:0] level;
  logic [NBTN-1:0] rise;
  logic [NBTN-1:0] evt_q, evt_d;
  logic [NBTN-1:0] evt_clr;
  bus_word_t       rdata_q, rdata_d;
  logic            hit_q, hit_d;
  logic            unused_wdata;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk  (clk),
      .res  (res),
      .btn_n(btn[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
    rdata_d = '0;
    hit_d   = 1'b0;
    evt_clr = '0;
    if (sel && ld) begin
      if (addr == ADDR_STAT) begin
        rdata_d[NBTN-1:0] = level;
        hit_d             = 1'b1;
      end else if (addr == ADDR_EVT) begin
        rdata_d[NBTN-1:0] = evt_q;
        hit_d             = 1'b1;
        evt_clr           = '1;
      end
    end else if (sel && !ld && (addr == ADDR_EVT)) begin
      evt_clr = wdata[NBTN-1:0];
    end
    // A press landing on the same edge as a clear must survive it.
    evt_d = (evt_q & ~evt_clr) | rise;
  end

  always_ff @(negedge clk or negedge res) begin
    if (!res) begin
      evt_q   <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      evt_q   <= evt_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
    end
  end

  assign rdata        = rdata_q;
  assign hit          = hit_q;
  assign pressed      = level;
  assign unused_wdata = ^wdata;

`ifdef BTN_INPUT_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = |evt_q;

  always_ff @(negedge clk or negedge res) begin
    if (!res) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: doc/btn_input_port.md
Name: btn_input_port

Overview:
- Memory-mapped input peripheral for the CPU data bus (RAM-side select/load interface). It is the input-direction counterpart of the digital-tube output register.
- Synchronises and debounces the active-low board push buttons.
- Latches press events in sticky bits that the CPU can clear.
- Returns button status or event bits on CPU loads to two fixed addresses; the tester muxes its rdata onto the RAM read path when hit=1.

Parameters:
- NBTN, 2, number of buttons (1..16)
- DEB_CYCLES, 500000, consecutive stable clk cycles needed to accept a level change (10 ms at 50 MHz)
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES
- ADDR_STAT, 12'd111, address of the read-only live debounced status
- ADDR_EVT, 12'd112, address of the sticky press-event register

Ports:
- clk  in  1  system clock; all flops update on the falling edge, matching memory bus timing
- res  in  1  asynchronous active-low reset
- btn  in  NBTN  raw board buttons, active-low, asynchronous
- addr  in  12  CPU data address
- sel  in  1  data-bus chip select
- ld  in  1  1 = load (CPU read), 0 = store (CPU write)
- wdata  in  16  CPU store data
- rdata  out  16  registered read data
- hit  out  1  registered; 1 when rdata is sourced by this block
- pressed  out  NBTN  debounced level, 1 = held

Behaviour:
- Reset (res=0, async) clears every flop: sync stages = 0, counters = 0, pressed = 0, evt = 0, rdata = 0, hit = 0, irq = 0.
- Input conditioning: raw_n = ~btn, passed through a 2-flop synchroniser.
- Debounce, per button:
  - If the synchronised value equals pressed[i], the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEB_CYCLES-1 while the value still differs, pressed[i] toggles and the counter clears.
  - Any glitch shorter than DEB_CYCLES restarts the count.
  - Latency from a btn edge to pressed: 2 (sync) + DEB_CYCLES cycles.
- Press event: a pressed[i] 0->1 transition sets evt[i] in the same cycle pressed updates. Release does not set evt.
- Read, on a falling edge with sel=1, ld=1:
  - addr==ADDR_STAT: rdata <= {zero-pad, pressed}, hit <= 1.
  - addr==ADDR_EVT: rdata <= {zero-pad, evt}, hit <= 1, and evt is cleared (read-to-clear).
  - Any other address, or sel=0: rdata <= 0, hit <= 0.
  - Read latency: 1 falling edge.
- Write, sel=1, ld=0:
  - addr==ADDR_EVT: write-1-to-clear, evt <= evt & ~wdata[NBTN-1:0].
  - Stores to ADDR_STAT are ignored.
  - Any write leaves rdata = 0 and hit = 0.
- Simultaneous events: a new press event in the same cycle as a read-clear or W1C of that bit wins, so evt[i] stays 1. In that case the read returns the pre-update value, so the new event is observed on the next read.
- Reset asserted mid-debounce or mid-read aborts the operation with no event generated. After release, btn already held low produces a press event after the full debounce latency.
- Unused high bits of rdata are always 0.

Optional Feature:
- Macro: BTN_INPUT_IRQ_EN.
- Defined: adds output port irq (1 bit), a registered OR of evt, updated on the same edge as evt.
  - Asserts 1 cycle after evt becomes nonzero.
  - Deasserts 1 cycle after evt is cleared.
  - Reset value 0.
- Undefined: no irq port exists and no extra logic is generated; all other behaviour is identical.

Decomposition:
- Shared package, btn_io_pkg:
  - ADDR_STAT and ADDR_EVT default constants
  - DATA_W = 16 and ADDR_W = 12
  - a typedef for the 16-bit bus word
- One natural sub-module, btn_debounce:
  - one synchroniser, counter and level per button
  - instantiated NBTN times in a generate loop
  - outputs the level and a one-cycle rise pulse

Test Plan (bench uses DEB_CYCLES=4, NBTN=2):
- Reset then idle btn=2'b11: read addr 111 -> rdata=16'h0000, hit=1; read addr 112 -> 16'h0000; read addr 50 -> hit=0, rdata=0.
- Hold btn[0]=0: pressed[0] rises exactly 6 cycles after the btn edge. Read 112 -> 16'h0001. Second read 112 -> 16'h0000.
- Glitch btn[1]=0 for 3 cycles, then 1 -> pressed stays 2'b00 and evt stays 0.
- Both buttons pressed and debounced -> evt=2'b11. Store wdata=16'h0002 to 112 -> evt=2'b01, and a subsequent read 112 returns 16'h0001.
- btn[1] press completes debounce on the same edge as a read of 112 -> read returns the old evt value, evt[1]=1 afterwards, and the next read returns bit1 set.
- Assert res low while the btn[0] counter=2 -> all outputs 0. After release with btn[0] still low, a press event occurs 6 cycles later. With BTN_INPUT_IRQ_EN defined, irq=1 one cycle after evt[0] sets.
